// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin IF/LS arbiter and sequencer for a word-wide Memory
module mem_port_arbiter #(
  parameter int MEM_BYTES = 131072
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_unsigned_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  inout  wire  [31:0] mem_bus_io
);

  typedef enum logic [1:0] {IDLE, READ, RMW_RD, WRITE} state_t;

  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);
  localparam logic        PORT_IF  = 1'b0;
  localparam logic        PORT_LS  = 1'b1;
  localparam logic [1:0]  SZ_BYTE  = 2'b00;
  localparam logic [1:0]  SZ_HALF  = 2'b01;
  localparam logic [1:0]  SZ_WORD  = 2'b10;
  localparam logic [1:0]  SZ_ILL   = 2'b11;

  state_t      state_q;
  logic        rr_q;
  logic        port_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        if_rvalid_q;
  logic        if_err_q;
  logic [31:0] if_rdata_q;
  logic        ls_rvalid_q;
  logic        ls_err_q;
  logic [31:0] ls_rdata_q;

  logic        idle;
  logic        pick_ls;
  logic        gnt;
  logic [31:0] g_addr;
  logic [1:0]  g_size;
  logic        g_bad;
  logic [31:0] load_ext;

  // Sign/zero extend the low lanes of a word read from Memory
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                         input logic uns);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = uns ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      SZ_HALF: r = uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Grant decode: only in IDLE; on contention the rr pointer picks the side
  always_comb begin
    idle     = (state_q == IDLE) && !rst_i;
    pick_ls  = ls_req_i && (!if_req_i || (rr_q == PORT_LS));
    if_gnt_o = idle && if_req_i && !pick_ls;
    ls_gnt_o = idle && pick_ls;
    gnt      = if_gnt_o || ls_gnt_o;
    g_addr   = pick_ls ? ls_addr_i : if_addr_i;
    g_size   = pick_ls ? ls_size_i : SZ_WORD;
    g_bad    = (g_addr > ADDR_MAX) || (g_size == SZ_ILL);
    load_ext = extend(mem_bus_io, size_q, uns_q);
  end

  // Sequencer FSM with registered Memory strobes and per-port responses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rr_q        <= PORT_LS;
      port_q      <= PORT_IF;
      uns_q       <= 1'b0;
      size_q      <= SZ_WORD;
      addr_q      <= '0;
      data_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt) begin
            port_q <= pick_ls;
            addr_q <= g_addr;
            size_q <= g_size;
            uns_q  <= pick_ls && ls_unsigned_i;
            data_q <= ls_wdata_i;
            if (if_req_i && ls_req_i) rr_q <= ~pick_ls;
            if (g_bad) begin
              // Rejected requests answer next cycle without touching Memory
              if (pick_ls) begin
                ls_rvalid_q <= 1'b1;
                ls_err_q    <= 1'b1;
                ls_rdata_q  <= '0;
              end else begin
                if_rvalid_q <= 1'b1;
                if_err_q    <= 1'b1;
                if_rdata_q  <= '0;
              end
            end else if (!(pick_ls && ls_we_i)) begin
              state_q    <= READ;
              mem_read_q <= 1'b1;
            end else if (g_size == SZ_WORD) begin
              state_q     <= WRITE;
              mem_write_q <= 1'b1;
            end else begin
              state_q    <= RMW_RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        READ: begin
          state_q    <= IDLE;
          mem_read_q <= 1'b0;
          if (port_q == PORT_LS) begin
            ls_rvalid_q <= 1'b1;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= load_ext;
          end else begin
            if_rvalid_q <= 1'b1;
            if_err_q    <= 1'b0;
            if_rdata_q  <= mem_bus_io;
          end
        end
        RMW_RD: begin
          // Merge the store lanes into the word just read, then write it back
          state_q     <= WRITE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          if (size_q == SZ_BYTE) data_q <= {mem_bus_io[31:8], data_q[7:0]};
          else                   data_q <= {mem_bus_io[31:16], data_q[15:0]};
        end
        WRITE: begin
          state_q     <= IDLE;
          mem_write_q <= 1'b0;
          ls_rvalid_q <= 1'b1;
          ls_err_q    <= 1'b0;
          ls_rdata_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign mem_address_o = (mem_read_q || mem_write_q) ? addr_q : '0;
  assign mem_bus_io    = mem_write_q ? data_q : 'z;
  assign if_rvalid_o   = if_rvalid_q;
  assign if_err_o      = if_err_q;
  assign if_rdata_o    = if_rdata_q;
  assign ls_rvalid_o   = ls_rvalid_q;
  assign ls_err_o      = ls_err_q;
  assign ls_rdata_o    = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_unsigned, ls_gnt, ls_rvalid, ls_err;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address;
  wire  [31:0] mem_bus;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
    string       nm;
  } exp_t;

  exp_t ifq[$];
  exp_t lsq[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  logic [7:0]  mem [0:1023] = '{default: 8'h00};
  logic [31:0] mem_rd;
  logic [9:0]  mi;

  mem_port_arbiter #(.MEM_BYTES(131072)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_size_i(ls_size),
    .ls_unsigned_i(ls_unsigned), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata), .ls_err_o(ls_err),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_address_o(mem_address),
    .mem_bus_io(mem_bus)
  );

  always #5 clk = ~clk;

  // Memory model: 1 KiB, aliased, little-endian bytes addr..addr+3
  always_comb begin
    mi     = mem_address[9:0];
    mem_rd = {mem[mi + 10'd3], mem[mi + 10'd2], mem[mi + 10'd1], mem[mi]};
  end
  assign mem_bus = mem_read ? mem_rd : 32'bz;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_read)  rd_cnt = rd_cnt + 1;
    if (mem_write) begin
      wr_cnt = wr_cnt + 1;
      mem[mi]          = mem_bus[7:0];
      mem[mi + 10'd1]  = mem_bus[15:8];
      mem[mi + 10'd2]  = mem_bus[23:16];
      mem[mi + 10'd3]  = mem_bus[31:24];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a port presents rvalid
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      tests++;
      if (mem_read && mem_write) begin
        failed++;
        $display("FAIL rw_overlap: mem_read and mem_write both 1 at cycle %0d", cyc);
      end
      if (if_rvalid) begin
        tests++;
        if (ifq.size() == 0) begin
          failed++;
          $display("FAIL if_unexpected_rvalid: rdata 0x%08h at cycle %0d", if_rdata, cyc);
        end else begin
          e = ifq.pop_front();
          if (if_rdata !== e.d || if_err !== e.e || cyc != e.c) begin
            failed++;
            $display("FAIL %s: got data 0x%08h err %0b cyc %0d expected 0x%08h err %0b cyc %0d",
                     e.nm, if_rdata, if_err, cyc, e.d, e.e, e.c);
          end
        end
      end
      if (ls_rvalid) begin
        tests++;
        if (lsq.size() == 0) begin
          failed++;
          $display("FAIL ls_unexpected_rvalid: rdata 0x%08h at cycle %0d", ls_rdata, cyc);
        end else begin
          e = lsq.pop_front();
          if (ls_rdata !== e.d || ls_err !== e.e || cyc != e.c) begin
            failed++;
            $display("FAIL %s: got data 0x%08h err %0b cyc %0d expected 0x%08h err %0b cyc %0d",
                     e.nm, ls_rdata, ls_err, cyc, e.d, e.e, e.c);
          end
        end
      end
    end
  end

  task automatic wait_gnt(input string nm, output logic ok);
    int n = 0;
    #1;
    while (!(if_gnt || ls_gnt) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    ok = if_gnt || ls_gnt;
    tests++;
    if (!ok) begin
      failed++;
      $display("FAIL %s_gnt_timeout: got no grant expected grant within 40 cycles", nm);
    end
  endtask

  task automatic if_op(input logic [31:0] a, input logic [31:0] d, input logic e,
                       input int lat, input logic push, input string nm);
    logic ok;
    @(negedge clk);
    if_addr = a; if_req = 1'b1;
    wait_gnt(nm, ok);
    if (ok && push) ifq.push_back('{d: d, e: e, c: cyc + lat, nm: nm});
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic ls_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] d,
                       input logic e, input int lat, input logic push, input string nm);
    logic ok;
    @(negedge clk);
    ls_we = we; ls_size = sz; ls_unsigned = uns; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
    wait_gnt(nm, ok);
    if (ok && push) lsq.push_back('{d: d, e: e, c: cyc + lat, nm: nm});
    @(posedge clk); #1;
    ls_req = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((ifq.size() != 0 || lsq.size() != 0) && n < 100) begin
      @(negedge clk); n++;
    end
    chk({nm, "_drain"}, 32'(ifq.size() + lsq.size()), 32'd0);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_gnt"},    {30'd0, if_gnt, ls_gnt}, 32'd0);
    chk({nm, "_rvalid"}, {28'd0, if_rvalid, if_err, ls_rvalid, ls_err}, 32'd0);
    chk({nm, "_if_rdata"}, if_rdata, 32'd0);
    chk({nm, "_ls_rdata"}, ls_rdata, 32'd0);
    chk({nm, "_mem_rw"}, {30'd0, mem_read, mem_write}, 32'd0);
    chk({nm, "_mem_addr"}, mem_address, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at 300000 expected finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    int   rd0, wr0;
    logic ok;
    logic exp_ls;
    int   nif, nls;
    rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; if_addr = '0;
    ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("t1_reset");
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk); rst = 1'b0;

    // T2: word store then fetch
    ls_op(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 32'h0, 1'b0, 2, 1'b1, "t2_sw_ack");
    if_op(32'h100, 32'h11223344, 1'b0, 2, 1'b1, "t2_fetch");
    ls_op(1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, "pre_sw_200");
    ls_op(1'b1, 2'b10, 1'b0, 32'h204, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1, "pre_sw_204");

    // T3: byte store and sub-word loads
    ls_op(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, 32'h0, 1'b0, 3, 1'b1, "t3_sb_ack");
    ls_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h1122A544, 1'b0, 2, 1'b1, "t3_lw");
    ls_op(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hFFFFFFA5, 1'b0, 2, 1'b1, "t3_lb");
    ls_op(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h000000A5, 1'b0, 2, 1'b1, "t3_lbu");

    // T4: half store
    ls_op(1'b1, 2'b01, 1'b0, 32'h102, 32'hFFFF8001, 32'h0, 1'b0, 3, 1'b1, "t4_sh_ack");
    ls_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8001A544, 1'b0, 2, 1'b1, "t4_lw");
    ls_op(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 2, 1'b1, "t4_lh");
    ls_op(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h00008001, 1'b0, 2, 1'b1, "t4_lhu");
    drain("t4");

    // T1: reset while a fetch is in READ
    if_op(32'h204, 32'h0, 1'b0, 2, 1'b0, "t1_inflight");
    rst = 1'b1;
    #1;
    chk_quiet("t1_midreset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // T5: both ports held, grants alternate starting with LS
    @(negedge clk);
    if_addr = 32'h204; if_req = 1'b1;
    ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 32'h200; ls_req = 1'b1;
    exp_ls = 1'b1; nif = 0; nls = 0;
    for (int g = 0; g < 8; g++) begin
      wait_gnt("t5", ok);
      if (ok) begin
        chk($sformatf("t5_grant%0d", g), {30'd0, if_gnt, ls_gnt},
            exp_ls ? 32'd1 : 32'd2);
        if (ls_gnt) begin
          lsq.push_back('{d: 32'hDEADBEEF, e: 1'b0, c: cyc + 2, nm: "t5_ls_load"});
          nls++;
        end else begin
          ifq.push_back('{d: 32'hCAFEF00D, e: 1'b0, c: cyc + 2, nm: "t5_if_fetch"});
          nif++;
        end
        exp_ls = ~exp_ls;
      end
      @(posedge clk); #1;
      if (nls >= 4) ls_req = 1'b0;
      if (nif >= 4) if_req = 1'b0;
    end
    ls_req = 1'b0; if_req = 1'b0;
    drain("t5");

    // T6: range and size errors never touch Memory
    rd0 = rd_cnt; wr0 = wr_cnt;
    ls_op(1'b0, 2'b10, 1'b0, 32'h1FFFE, 32'h0, 32'h0, 1'b1, 1, 1'b1, "t6_lw_range");
    ls_op(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 1'b1, "t6_size11");
    ls_op(1'b1, 2'b10, 1'b0, 32'h1FFFD, 32'h12345678, 32'h0, 1'b1, 1, 1'b1, "t6_sw_range");
    drain("t6");
    chk("t6_no_mem_cycles", 32'(rd_cnt - rd0 + wr_cnt - wr0), 32'd0);
    if_op(32'h1FFFD, 32'h0, 1'b1, 1, 1'b1, "t6_if_range");
    ls_op(1'b0, 2'b10, 1'b0, 32'h1FFFC, 32'h0, 32'h0, 1'b0, 2, 1'b1, "t6_lw_last_legal");
    drain("t6b");

    // T7: reset during the read half of a byte store
    wr0 = wr_cnt;
    ls_op(1'b1, 2'b00, 1'b0, 32'h100, 32'h00000077, 32'h0, 1'b0, 3, 1'b0, "t7_sb");
    chk("t7_in_rmw_rd", {31'd0, mem_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk_quiet("t7_reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t7_no_write", 32'(wr_cnt - wr0), 32'd0);
    chk("t7_word_kept", {mem[10'h103], mem[10'h102], mem[10'h101], mem[10'h100]}, 32'h8001A544);
    ls_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h8001A544, 1'b0, 2, 1'b1, "t7_lw_after");
    drain("t7");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
